// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART receiver and transmitter.
//   rx_state_t     : receiver FSM state encoding
//   OVERSAMPLE_DEF : default number of sample ticks per bit
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input bit.
//   clk   : destination clock
//   reset : synchronous active-high reset, both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (2 clk latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity.
//   clk, reset   : system clock, synchronous active-high reset
//   sample_tick  : one-cycle pulse at OVERSAMPLE x baud
//   rx           : asynchronous serial input, idles high
//   parity_en    : parity bit present after the data bits
//   parity_odd   : 1 = odd parity, 0 = even parity
//   data_out     : last received word (LSB received first)
//   data_valid   : one-cycle strobe at frame completion
//   parity_err   : parity mismatch in the last frame
//   frame_err    : stop bit sampled low in the last frame
//   busy         : receiver is inside a frame
// DATA_BITS must be 5..9; OVERSAMPLE must be even and >= 8.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic rx_s;
  logic rx_s_d_reg;
  logic fall_edge;

  rx_state_t             state_reg;
  logic [TICK_W-1:0]     tick_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  par_acc_reg;   // running XOR of received data bits
  logic                  par_bad_reg;   // parity result of the current frame
  logic                  par_en_reg;    // mode captured at start-bit validation
  logic                  par_odd_reg;
  logic [DATA_BITS-1:0]  data_out_reg;
  logic                  data_valid_reg;
  logic                  parity_err_reg;
  logic                  frame_err_reg;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // A line held low never produces a second edge, so a break yields one frame.
  assign fall_edge = rx_s_d_reg & ~rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s_d_reg     <= 1'b1;
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_acc_reg    <= 1'b0;
      par_bad_reg    <= 1'b0;
      par_en_reg     <= 1'b0;
      par_odd_reg    <= 1'b0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_s_d_reg     <= rx_s;
      data_valid_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          // A tick coincident with the edge is deliberately not counted.
          if (fall_edge) begin
            state_reg    <= START;
            tick_cnt_reg <= '0;
          end
        end

        START: begin
          if (sample_tick) begin
            if (tick_cnt_reg == TICK_MID) begin
              if (rx_s) begin
                state_reg <= IDLE;       // glitch, not a start bit
              end else begin
                state_reg    <= DATA;
                tick_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
                par_acc_reg  <= 1'b0;
                par_bad_reg  <= 1'b0;
                par_en_reg   <= parity_en;
                par_odd_reg  <= parity_odd;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end

        DATA: begin
          if (sample_tick) begin
            if (tick_cnt_reg == TICK_END) begin
              tick_cnt_reg <= '0;
              shift_reg    <= {rx_s, shift_reg[DATA_BITS-1:1]};
              par_acc_reg  <= par_acc_reg ^ rx_s;
              bit_cnt_reg  <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == BIT_LAST)
                state_reg <= par_en_reg ? PARITY : STOP;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end

        PARITY: begin
          if (sample_tick) begin
            if (tick_cnt_reg == TICK_END) begin
              tick_cnt_reg <= '0;
              par_bad_reg  <= (par_acc_reg ^ rx_s) != par_odd_reg;
              state_reg    <= STOP;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end

        STOP: begin
          // Leave mid-stop-bit so a back-to-back start edge is not missed.
          if (sample_tick) begin
            if (tick_cnt_reg == TICK_END) begin
              tick_cnt_reg   <= '0;
              data_out_reg   <= shift_reg;
              parity_err_reg <= par_en_reg & par_bad_reg;
              frame_err_reg  <= ~rx_s;
              data_valid_reg <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx with a scoreboard of
// expected frames; sample_tick runs at half the clk rate.
module tb_uart_rx;

  localparam int DB       = 8;
  localparam int OS       = 16;
  localparam int TICK_DIV = 2;
  localparam int BIT_CLKS = OS * TICK_DIV;

  typedef struct packed {
    logic [DB-1:0] data;
    logic          perr;
    logic          ferr;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_tick;
  logic          rx;
  logic          parity_en;
  logic          parity_odd;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  exp_t sb_q[$];
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  int   pulse_cnt  = 0;
  int   tick_num   = 0;
  int   last_pulse_tick = 0;
  int   prev_pulse_tick = 0;

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .rx          (rx),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever @(negedge clk) sample_tick = ~sample_tick;
  end

  always @(posedge clk) if (sample_tick) tick_num <= tick_num + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every data_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (data_valid) begin
      exp_t e;
      pulse_cnt++;
      prev_pulse_tick = last_pulse_tick;
      last_pulse_tick = tick_num;
      check("dv_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("parity_err", 32'(parity_err), 32'(e.perr));
        check("frame_err", 32'(frame_err), 32'(e.ferr));
        $display("frame: data_out=%02h parity_err=%0b frame_err=%0b (exp %02h %0b %0b)",
                 data_out, parity_err, frame_err, e.data, e.perr, e.ferr);
      end
    end
  end

  task automatic push_exp(input logic [DB-1:0] d, input logic pen, input logic podd,
                          input logic pbit, input logic stop);
    exp_t e;
    logic good_bit;
    // Even parity: bit makes total ones even; odd parity: total ones odd.
    good_bit = podd ? ~(^d) : (^d);
    e.data = d;
    e.perr = pen ? (pbit != good_bit) : 1'b0;
    e.ferr = ~stop;
    sb_q.push_back(e);
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic pen,
                            input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic wait_pulses(input string tag, input int n);
    int budget = 4 * BIT_CLKS;
    while (pulse_cnt < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, 32'(pulse_cnt), 32'(n));
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  initial begin
    int gap;
    reset = 1'b1; rx = 1'b1; parity_en = 1'b0; parity_odd = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_parity_err", 32'(parity_err), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    idle_bits(1);

    // 0xA5, no parity
    push_exp(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    wait_pulses("pulses_a5", 1);
    check("busy_after_a5", 32'(busy), 32'h0);

    // 0x3C even parity, correct bit 0
    parity_en = 1'b1; parity_odd = 1'b0;
    push_exp(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    wait_pulses("pulses_3c_even_ok", 2);

    // 0x3C odd parity, bit 1 is correct
    parity_odd = 1'b1;
    push_exp(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    wait_pulses("pulses_3c_odd_ok", 3);

    // 0x3C even parity, wrong bit 1; mode flipped mid-frame must be ignored
    parity_odd = 1'b0;
    push_exp(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    parity_odd = 1'b1; parity_en = 1'b0;
    for (int i = 1; i < DB; i++) send_bit(((8'h3C >> i) & 8'h01) != 0);
    send_bit(1'b1);
    send_bit(1'b1);
    parity_odd = 1'b0; parity_en = 1'b1;
    idle_bits(1);
    wait_pulses("pulses_3c_even_bad", 4);

    // Glitch: low for 4 sample ticks, then high
    rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (OS / 2 * TICK_DIV + 14) @(negedge clk);
    check("glitch_busy_low", 32'(busy), 32'h0);
    check("glitch_no_pulse", 32'(pulse_cnt), 32'd4);
    check("glitch_data_held", 32'(data_out), 32'h3C);
    check("glitch_perr_held", 32'(parity_err), 32'h1);
    idle_bits(1);

    // 0x55 with stop bit 0, then a 40-bit-time break
    parity_en = 1'b0;
    push_exp(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (40 * BIT_CLKS) @(negedge clk);
    check("break_one_pulse", 32'(pulse_cnt), 32'd5);
    check("break_busy", 32'(busy), 32'h0);
    check("break_ferr_held", 32'(frame_err), 32'h1);
    idle_bits(2);
    check("break_no_retrigger", 32'(pulse_cnt), 32'd5);

    // Reset after 3 data bits of an aborted frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    reset = 1'b1; rx = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_data_out", 32'(data_out), 32'h0);
    check("midrst_frame_err", 32'(frame_err), 32'h0);
    check("midrst_parity_err", 32'(parity_err), 32'h0);
    idle_bits(2);
    check("midrst_no_pulse", 32'(pulse_cnt), 32'd5);

    push_exp(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    wait_pulses("pulses_81", 6);

    // Back-to-back 0x00 and 0xFF, zero idle gap
    push_exp(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    push_exp(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    wait_pulses("pulses_b2b", 8);
    gap = last_pulse_tick - prev_pulse_tick;
    check("b2b_gap_in_range", 32'(gap >= (DB + 2) * OS - 1 && gap <= (DB + 2) * OS + 1), 32'h1);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
